// File: rtl/spi_cipher_responder_if.sv
// rtl/spi_cipher_responder_if.sv - SPI pin bundle between master and cipher responder
interface spi_cipher_responder_if;
  logic sclk;
  logic cs;
  logic sdi;
  logic sdo;

  modport slave  (input sclk, input cs, input sdi, output sdo);
  modport master (output sclk, output cs, output sdi, input sdo);
endinterface

// File: rtl/spi_cipher_responder.sv
// rtl/spi_cipher_responder.sv - oversampling SPI mode-0 responder feeding key/msg to the AES path
module spi_cipher_responder #(
  parameter int nk      = 8,
  parameter int nb      = 4,
  parameter int nr      = 14,
  parameter int RES_LAT = 2
) (
  input  logic                in_clk,
  input  logic                rst,
  spi_cipher_responder_if.slave spi,
  output logic [32*nk-1:0]    to_enc_dec_key,
  output logic [32*nb-1:0]    to_enc_dec_msg,
  input  logic [32*nb-1:0]    from_enc_dec_msg,
  output logic                data_done,
  output logic                result_ready,
  output logic                frame_err
);

  localparam int KW = 32 * nk;
  localparam int MW = 32 * nb;
  localparam int FL = KW + MW;
  localparam int CW = $clog2(FL + 1);

  if (RES_LAT < 1 || RES_LAT > 15 || nr != nk + 6) begin : g_param_check
    $error("spi_cipher_responder: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic           sclk_prev_q, cs_prev_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FL-1:0]  rx_q, rx_d;
  logic [MW-1:0]  tx_q, tx_d;
  logic [MW-1:0]  res_q, res_d;
  logic [KW-1:0]  key_q, key_d;
  logic [MW-1:0]  msg_q, msg_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           pend_q, pend_d;
  logic [3:0]     lat_q, lat_d;

  logic           sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic           rx_en, shift_bit, lat_hit;
  logic [CW-1:0]  cnt_inc;
  logic [FL-1:0]  rx_after;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;
  assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;

  // A frame that started while waiting for the cipher keeps sampling bits.
  assign rx_en     = (state_q == S_SHIFT) || ((state_q == S_WAIT) && pend_q);
  assign shift_bit = rx_en && sclk_rise && (cnt_q < CW'(FL));
  assign cnt_inc   = shift_bit ? cnt_q + 1'b1 : cnt_q;
  assign rx_after  = shift_bit ? {rx_q[FL-2:0], sdi_sync_q[1]} : rx_q;
  assign lat_hit   = (lat_q == 4'(RES_LAT - 1));

  assign spi.sdo        = tx_q[MW-1] & ~cs_sync_q[1];
  assign to_enc_dec_key = key_q;
  assign to_enc_dec_msg = msg_q;
  assign data_done      = done_q;
  assign result_ready   = ready_q;
  assign frame_err      = err_q;

  // Synchronize the asynchronous SPI pins and keep previous values for edge detection.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[0], spi.cs};
      sdi_sync_q  <= {sdi_sync_q[0], spi.sdi};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  // FSM state register.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: frame start, frame end (full or short), cipher settle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cs_fall) state_d = S_SHIFT;
      S_SHIFT: if (cs_rise) state_d = (cnt_inc == CW'(FL)) ? S_WAIT : S_IDLE;
      S_WAIT:  if (lat_hit) state_d = (pend_q || cs_fall) ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the shift registers, result capture and pulses.
  always_comb begin
    cnt_d   = cnt_inc;
    rx_d    = rx_after;
    tx_d    = tx_q;
    res_d   = res_q;
    key_d   = key_q;
    msg_d   = msg_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pend_d  = pend_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          tx_d    = res_q;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (sclk_fall) tx_d = {tx_q[MW-2:0], 1'b0};
        if (cs_rise) begin
          if (cnt_inc == CW'(FL)) begin
            key_d  = rx_after[FL-1:MW];
            msg_d  = rx_after[MW-1:0];
            done_d = 1'b1;
            lat_d  = '0;
            pend_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cs_fall) begin
          pend_d = 1'b1;
          cnt_d  = '0;
        end
        if (cs_rise) pend_d = 1'b0;
        if (lat_hit) begin
          res_d = from_enc_dec_msg;
          if (pend_q || cs_fall) begin
            tx_d    = from_enc_dec_msg;
            ready_d = 1'b0;
            pend_d  = 1'b0;
          end else begin
            ready_d = 1'b1;
          end
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      res_q   <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      lat_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      res_q   <= res_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: tb/tb_spi_cipher_responder.sv
// tb/tb_spi_cipher_responder.sv - scoreboard bench for the SPI cipher responder
module tb_spi_cipher_responder;
  localparam int NK = 8;
  localparam int NB = 4;
  localparam int NR = 14;
  localparam int RES_LAT = 2;
  localparam int KW = 32 * NK;
  localparam int MW = 32 * NB;
  localparam int FL = KW + MW;

  localparam logic [KW-1:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [MW-1:0] M1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [MW-1:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          in_clk = 1'b0;
  logic          rst;
  logic [KW-1:0] key;
  logic [MW-1:0] msg;
  logic [MW-1:0] from_core;
  logic          data_done, result_ready, frame_err;

  always #5 in_clk = ~in_clk;

  spi_cipher_responder_if spi ();

  spi_cipher_responder #(.nk(NK), .nb(NB), .nr(NR), .RES_LAT(RES_LAT)) dut (
    .in_clk           (in_clk),
    .rst              (rst),
    .spi              (spi.slave),
    .to_enc_dec_key   (key),
    .to_enc_dec_msg   (msg),
    .from_enc_dec_msg (from_core),
    .data_done        (data_done),
    .result_ready     (result_ready),
    .frame_err        (frame_err)
  );

  // Stand-in encryption core: the known AES-256 vector, otherwise an arbitrary mix.
  function automatic logic [MW-1:0] cipher(input logic [KW-1:0] k, input logic [MW-1:0] m);
    if (k == K1 && m == M1) return C1;
    return m ^ k[MW-1:0] ^ k[KW-1:MW] ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  assign from_core = cipher(key, msg);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct {
    bit            is_err;
    logic [KW-1:0] k;
    logic [MW-1:0] m;
  } ev_t;

  typedef struct {
    logic [MW-1:0] c;
    bit            tail_ok;
  } sdo_t;

  ev_t  exp_ev_q[$];
  sdo_t exp_sdo_q[$];
  sdo_t act_sdo_q[$];

  // Monitor: compares frame-end pulses and returned sdo words against the queues.
  ev_t  mon_ev;
  sdo_t mon_a, mon_e;
  bit   prev_pulse = 1'b0;
  initial begin
    forever begin
      @(negedge in_clk);
      if (!rst) begin
        if (data_done || frame_err) begin
          if (prev_pulse) check("pulse_width", 1'b1, 1'b0);
          if (exp_ev_q.size() == 0) begin
            check("unexpected_event", {data_done, frame_err}, 2'b00);
          end else begin
            mon_ev = exp_ev_q.pop_front();
            check("event_err", frame_err, mon_ev.is_err);
            check("event_done", data_done, !mon_ev.is_err);
            check("event_key", key, mon_ev.k);
            check("event_msg", msg, mon_ev.m);
          end
        end
        prev_pulse = data_done | frame_err;
      end
      while (act_sdo_q.size() > 0 && exp_sdo_q.size() > 0) begin
        mon_a = act_sdo_q.pop_front();
        mon_e = exp_sdo_q.pop_front();
        check("sdo_cipher", mon_a.c, mon_e.c);
        check("sdo_tail_zero", mon_a.tail_ok, mon_e.tail_ok);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  // SPI master, sclk = in_clk/8; bits beyond FL are sent as ones.
  task automatic send_frame(input logic [FL-1:0] data, input int nbits, input bit end_frame);
    logic [MW-1:0] cap;
    bit            tail_ok;
    sdo_t          s;
    cap     = '0;
    tail_ok = 1'b1;
    spi.cs  = 1'b0;
    cyc(8);
    for (int i = 0; i < nbits; i++) begin
      spi.sdi = (i < FL) ? data[FL-1-i] : 1'b1;
      cyc(4);
      if (i < MW) cap = {cap[MW-2:0], spi.sdo};
      else if (spi.sdo !== 1'b0) tail_ok = 1'b0;
      spi.sclk = 1'b1;
      cyc(4);
      spi.sclk = 1'b0;
    end
    if (end_frame) begin
      cyc(4);
      spi.cs    = 1'b1;
      s.c       = cap;
      s.tail_ok = tail_ok;
      act_sdo_q.push_back(s);
    end
  endtask

  task automatic expect_frame(input bit is_err, input logic [KW-1:0] k, input logic [MW-1:0] m,
                              input logic [MW-1:0] c);
    ev_t  e;
    sdo_t s;
    e.is_err  = is_err;
    e.k       = k;
    e.m       = m;
    s.c       = c;
    s.tail_ok = 1'b1;
    exp_ev_q.push_back(e);
    exp_sdo_q.push_back(s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key"}, key, '0);
    check({tag, "_msg"}, msg, '0);
    check({tag, "_sdo"}, spi.sdo, 1'b0);
    check({tag, "_ready"}, result_ready, 1'b0);
    check({tag, "_done"}, data_done, 1'b0);
    check({tag, "_err"}, frame_err, 1'b0);
  endtask

  logic [KW-1:0] k2, k3, k4, k5, k6, k7;
  logic [MW-1:0] m2, m3, m4, m5, m6, m7;
  logic [MW-1:0] exp_res;
  int            lat;
  bit            seen;

  initial begin
    k2 = {8{32'hdeadbeef}};  m2 = 128'h0123456789abcdeffedcba9876543210;
    k3 = {8{32'h13579bdf}};  m3 = 128'hffffffff00000000aaaaaaaa55555555;
    k4 = {8{32'hc001d00d}};  m4 = 128'h1111222233334444555566667777888a;
    k5 = {8{32'h2468ace0}};  m5 = 128'h00000000000000000000000000000001;
    k6 = {8{32'h5a5aa5a5}};  m6 = 128'h80000000000000000000000000000000;
    k7 = {8{32'h0badcafe}};  m7 = 128'h3c3c3c3cc3c3c3c30f0f0f0ff0f0f0f0;

    rst = 1'b1;
    spi.cs = 1'b1;
    spi.sclk = 1'b0;
    spi.sdi = 1'b0;
    cyc(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc(4);

    // Frame 1: AES-256 vector, returns zeros since nothing was captured yet.
    expect_frame(1'b0, K1, M1, '0);
    send_frame({K1, M1}, FL, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge in_clk);
      seen = data_done;
    end
    check("frame1_done_seen", seen, 1'b1);
    check("ready_low_at_done", result_ready, 1'b0);
    lat = 0;
    while (!result_ready && lat < 10) begin
      @(negedge in_clk);
      lat++;
    end
    check("ready_latency_ok", (lat >= 1 && lat <= RES_LAT + 1), 1'b1);
    cyc(10);
    exp_res = C1;

    // Frame 2: returns the AES cipher of frame 1.
    expect_frame(1'b0, k2, m2, exp_res);
    send_frame({k2, m2}, FL, 1'b1);
    cyc(20);
    check("ready_after_frame2", result_ready, 1'b1);
    exp_res = cipher(k2, m2);

    // Short frame: error, key/msg held, result register kept for the next frame.
    expect_frame(1'b1, k2, m2, exp_res);
    send_frame({k3, m3}, 200, 1'b1);
    cyc(20);
    check("key_after_short", key, k2);
    check("ready_after_short", result_ready, 1'b0);

    // Long frame: extra 5 bits ignored.
    expect_frame(1'b0, k4, m4, exp_res);
    send_frame({k4, m4}, FL + 5, 1'b1);
    cyc(20);
    exp_res = cipher(k4, m4);

    // Reset in the middle of a frame.
    send_frame({k5, m5}, 100, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    cyc(3);
    spi.cs = 1'b1;
    spi.sclk = 1'b0;
    spi.sdi = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(6);
    exp_res = '0;

    expect_frame(1'b0, k5, m5, exp_res);
    send_frame({k5, m5}, FL, 1'b1);
    cyc(20);
    exp_res = cipher(k5, m5);

    // Back-to-back frames: second cs fall lands in the settle window.
    expect_frame(1'b0, k6, m6, exp_res);
    expect_frame(1'b0, k7, m7, cipher(k6, m6));
    send_frame({k6, m6}, FL, 1'b1);
    cyc(1);
    send_frame({k7, m7}, FL, 1'b1);
    cyc(30);

    check("events_left", exp_ev_q.size(), 0);
    check("sdo_exp_left", exp_sdo_q.size(), 0);
    check("sdo_act_left", act_sdo_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
